// File: rtl/morse_arbiter.sv
// Round-robin arbiter granting one of four requesters exclusive use of a morse
// blinker: load the word, let it play for SLOT_CYCLES, then hold the blinker idle for GAP_CYCLES.
//
// state | meaning
// IDLE  | no owner; arbitrate among active requests
// LOAD  | one cycle: strobe the granted word into the blinker
// PLAY  | blinker runs for SLOT_CYCLES with the grant held
// GAP   | blinker forced idle for GAP_CYCLES, then back to IDLE
module morse_arbiter #(
  parameter logic [31:0] SLOT_CYCLES = 32'd50000000,
  parameter logic [31:0] GAP_CYCLES  = 32'd5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] req_word,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [15:0] blink_data,
  output logic        blink_set,
  output logic        blink_reset,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [31:0] r_cnt;

  logic [1:0]  w_idx;
  logic [1:0]  w_cand;
  logic        w_hit;
  logic [3:0]  w_onehot;
  logic [15:0] w_word;
  logic        w_keep;

  // Scan offsets from high to low so the smallest offset from r_ptr wins.
  always_comb begin
    w_idx  = r_ptr;
    w_cand = 2'd0;
    w_hit  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_ptr + 2'(k);
      if (req[w_cand]) begin
        w_idx = w_cand;
        w_hit = 1'b1;
      end
    end
  end

  assign w_onehot = 4'b0001 << w_idx;
  assign w_word   = req_word[{w_idx, 4'b0000} +: 16];
  assign w_keep   = |(req & grant);
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd0;
      r_cnt       <= 32'd0;
      grant       <= 4'b0000;
      done        <= 4'b0000;
      blink_data  <= 16'h0000;
      blink_set   <= 1'b0;
      blink_reset <= 1'b0;
    end else begin
      done <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            grant       <= w_onehot;
            r_ptr       <= w_idx + 2'd1;
            blink_data  <= w_word;
            blink_set   <= 1'b1;
            blink_reset <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          blink_set <= 1'b0;
          if (w_keep) begin
            r_cnt   <= SLOT_CYCLES - 32'd1;
            r_state <= S_PLAY;
          end else begin
            grant       <= 4'b0000;
            blink_reset <= 1'b0;
            r_cnt       <= GAP_CYCLES - 32'd1;
            r_state     <= S_GAP;
          end
        end
        S_PLAY: begin
          // A dropped request wins over a normal finish: no done pulse on abort.
          if (!w_keep) begin
            grant       <= 4'b0000;
            blink_reset <= 1'b0;
            r_cnt       <= GAP_CYCLES - 32'd1;
            r_state     <= S_GAP;
          end else if (r_cnt == 32'd0) begin
            done        <= grant;
            grant       <= 4'b0000;
            blink_reset <= 1'b0;
            r_cnt       <= GAP_CYCLES - 32'd1;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 32'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
